lamp_sequencer: RTL and testbench

LAMP_SEQUENCER -- requirements
Module: lamp_sequencer

---
 rtl/lamp_sequencer.sv | 86 ++++++++
 tb/tb_lamp_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lamp_sequencer.sv
// Thermometer-coded lamp bar that ramps one lamp at a time toward a requested count,
// spacing each single-lamp change by STEP_CYCLES clocks.
module lamp_sequencer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        target_valid,
    input  logic [3:0]  target,
    output logic        target_ready,
    output logic [14:0] lamps,
    output logic [3:0]  lit_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    localparam logic [7:0] RELOAD = 8'(STEP_CYCLES - 1);

    state_t     state;
    logic [3:0] goal;
    logic [7:0] timer;
    logic [3:0] step_count;

    // Only evaluated while ramping, where the goal bounds the count, so it cannot wrap.
    assign step_count = (state == RAMP_UP) ? lit_count + 4'd1 : lit_count - 4'd1;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lit_count <= 4'd0;
            goal      <= 4'd0;
            timer     <= 8'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (target_valid) begin
                        goal <= target;
                        if (target > lit_count) begin
                            state <= RAMP_UP;
                            timer <= RELOAD;
                        end else if (target < lit_count) begin
                            state <= RAMP_DOWN;
                            timer <= RELOAD;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        timer     <= RELOAD;
                        lit_count <= step_count;
                        if (step_count == goal) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign target_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // NOTE: every bit is assigned on every pass, so no latch is inferred.
    always_comb begin
        lamps = '0;
        for (int i = 0; i < 15; i++) begin
            lamps[i] = (4'(i) < lit_count);
        end
    end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Scoreboard bench: stimulus predicts lamp-change/done events from ramp arithmetic,
// an independent monitor pops them whenever the DUT shows a count change or done.
module tb_lamp_sequencer;

    localparam int STEP = 4;

    typedef struct {
        int cyc;
        int count;
        bit done;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        target_valid = 1'b1;
    logic [3:0]  target = 4'd9;
    logic        target_ready, busy, done;
    logic [14:0] lamps;
    logic [3:0]  lit_count;

    logic        valid1 = 1'b0;
    logic [3:0]  target1 = 4'd0;
    logic        ready1, busy1, done1;
    logic [14:0] lamps1;
    logic [3:0]  lit1;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    ev_t sb[$];

    // Reference model: the ramp in progress, described by its start, goal and accept edge.
    int m_base = 0, m_tgt = 0, m_e0 = 0, m_free_at = 0;

    lamp_sequencer #(.STEP_CYCLES(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .target_valid(target_valid), .target(target),
        .target_ready(target_ready), .lamps(lamps), .lit_count(lit_count),
        .busy(busy), .done(done)
    );

    lamp_sequencer #(.STEP_CYCLES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .target_valid(valid1), .target(target1),
        .target_ready(ready1), .lamps(lamps1), .lit_count(lit1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [14:0] therm(input int n);
        logic [15:0] t;
        t = (16'd1 << n) - 16'd1;
        return t[14:0];
    endfunction

    function automatic int model_count(input int c);
        int n, k;
        n = (m_tgt > m_base) ? m_tgt - m_base : m_base - m_tgt;
        if (c <= m_e0) return m_base;
        k = (c - m_e0) / STEP;
        if (k > n) k = n;
        return (m_tgt > m_base) ? m_base + k : m_base - k;
    endfunction

    // Apply inputs for exactly one upcoming edge and predict its consequences.
    task automatic drive(input bit v, input int t, input bit r);
        int e, c, n;
        @(negedge clk);
        #1;
        target_valid = v;
        target       = 4'(t);
        rst_n        = r;
        e = cyc + 1;
        if (!r) begin
            c = model_count(e - 1);
            sb.delete();
            if (c != 0) sb.push_back('{cyc: e, count: 0, done: 1'b0});
            m_base = 0; m_tgt = 0; m_e0 = e; m_free_at = e;
        end else if (v && (e - 1 >= m_free_at)) begin
            c = model_count(e - 1);
            n = (t > c) ? t - c : c - t;
            if (n == 0) sb.push_back('{cyc: e, count: c, done: 1'b1});
            for (int k = 1; k <= n; k++)
                sb.push_back('{cyc: e + k * STEP, count: (t > c) ? c + k : c - k, done: (k == n)});
            m_base = c; m_tgt = t; m_e0 = e; m_free_at = e + n * STEP;
        end
    endtask

    task automatic wait_idle();
        while (cyc < m_free_at + 1) drive(0, 0, 1);
    endtask

    always @(negedge clk) begin : monitor
        static logic [3:0] prev = 4'd0;
        ev_t ev;
        bit  exp_busy;
        if (mon_en) begin
            exp_busy = (cyc < m_free_at);
            check("busy", busy, exp_busy);
            check("target_ready", target_ready, !exp_busy);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                check("missed_event_cycle", cyc, ev.cyc);
            end
            if (lit_count != prev || done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event at cycle %0d: got lit_count=%0d done=%0b, expected no event",
                             cyc, lit_count, done);
                end else begin
                    ev = sb.pop_front();
                    check("event_cycle", cyc, ev.cyc);
                    check("lit_count", lit_count, ev.count);
                    check("done", done, ev.done);
                    check("lamps", lamps, therm(ev.count));
                end
            end
            prev = lit_count;
        end
    end

    initial begin
        int e_mid;

        // Reset with a request held high: it must be discarded.
        drive(1, 9, 0);
        drive(1, 9, 0);
        drive(0, 0, 1);
        check("rst_lamps", lamps, 15'h0000);
        check("rst_lit_count", lit_count, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", target_ready, 1);
        check("rst_done", done, 0);
        mon_en = 1'b1;

        // Ramp 0->5 with an ignored request for 15 part-way through.
        drive(1, 5, 1);
        repeat (6) drive(0, 0, 1);
        drive(1, 15, 1);
        wait_idle();
        check("up_lamps", lamps, 15'h001F);
        check("up_ready", target_ready, 1);

        drive(1, 2, 1);
        wait_idle();
        check("down_lamps", lamps, 15'h0003);

        drive(1, 2, 1);
        wait_idle();
        check("equal_lamps", lamps, 15'h0003);

        drive(0, 0, 0);
        drive(0, 0, 1);
        drive(1, 9, 1);
        e_mid = cyc + 1;
        while (cyc < e_mid + 12) drive(0, 0, 1);
        check("mid_count_before_rst", lit_count, 3);
        drive(0, 0, 0);
        drive(0, 0, 1);
        check("mid_rst_count", lit_count, 0);
        check("mid_rst_ready", target_ready, 1);

        // Randomized traffic: requests, requests while busy, occasional resets.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 11) == 0)
                drive($urandom_range(0, 1), $urandom_range(0, 15), 0);
            else
                drive(1, $urandom_range(0, 15), 1);
            repeat ($urandom_range(0, 40)) drive(0, 0, 1);
        end
        wait_idle();
        repeat (3) drive(0, 0, 1);
        check("scoreboard_empty", sb.size(), 0);

        // Full-scale ramp with single-cycle steps.
        @(negedge clk);
        #1;
        valid1  = 1'b1;
        target1 = 4'd15;
        @(negedge clk);
        #1;
        valid1 = 1'b0;
        check("fast_accept_count", lit1, 0);
        check("fast_accept_busy", busy1, 1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("fast_count", lit1, k);
            check("fast_done", done1, (k == 15));
            check("fast_lamps", lamps1, therm(k));
        end
        @(negedge clk);
        check("fast_done_after", done1, 0);
        check("fast_ready_after", ready1, 1);
        check("fast_lamps_full", lamps1, 15'h7FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
